// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RV32I memory stage; one load/store in flight on a req/ack bus.
// Ports: in_* op from execute, mem_* word bus, resp_*/err_* to writeback.
// Optional LSU_TIMEOUT_EN: bus timeout after WAIT_LIMIT request cycles (cause 2).
module lsu_mem_stage #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_store,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        err_valid,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state;
  logic [2:0]  op_f3;
  logic [1:0]  op_lo;
  logic        op_store;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] LAST = 16'(WAIT_LIMIT - 1);
  logic [15:0] wait_cnt;
  logic [31:0] op_addr;
`endif

  logic        illegal;
  logic        misal;
  logic [3:0]  st_be;
  logic [31:0] st_wd;

  // Decode of the op being offered; only feeds registers.
  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    st_be   = 4'hF;
    st_wd   = in_wdata;
    if (in_store)
      illegal = in_funct3[2] | (in_funct3[1:0] == 2'd3);
    else
      illegal = (in_funct3[1:0] == 2'd3) | (in_funct3[2] & in_funct3[1]);
    unique case (in_funct3[1:0])
      2'd0: begin
        st_be = 4'b0001 << in_addr[1:0];
        st_wd = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        misal = in_addr[0];
        st_be = in_addr[1] ? 4'b1100 : 4'b0011;
        st_wd = {2{in_wdata[15:0]}};
      end
      2'd2: misal = (in_addr[1:0] != 2'd0);
      default: ;
    endcase
  end

  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_data;

  // Lane select and extension of the returned word.
  always_comb begin
    lb = mem_rdata[7:0];
    unique case (op_lo)
      2'd1:    lb = mem_rdata[15:8];
      2'd2:    lb = mem_rdata[23:16];
      2'd3:    lb = mem_rdata[31:24];
      default: lb = mem_rdata[7:0];
    endcase
    lh = op_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (op_f3)
      3'd0:    ld_data = {{24{lb[7]}}, lb};
      3'd1:    ld_data = {{16{lh[15]}}, lh};
      3'd4:    ld_data = {24'd0, lb};
      3'd5:    ld_data = {16'd0, lh};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rd    <= '0;
      resp_data  <= '0;
      err_valid  <= 1'b0;
      err_cause  <= '0;
      err_addr   <= '0;
      op_f3      <= '0;
      op_lo      <= '0;
      op_store   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt   <= '0;
      op_addr    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            op_f3    <= in_funct3;
            op_lo    <= in_addr[1:0];
            op_store <= in_store;
            resp_rd  <= in_rd;
`ifdef LSU_TIMEOUT_EN
            op_addr  <= in_addr;
            wait_cnt <= '0;
`endif
            if (illegal || misal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_we    <= 1'b0;
              resp_data  <= '0;
              err_valid  <= 1'b1;
              err_cause  <= illegal ? 2'd3 : (in_store ? 2'd1 : 2'd0);
              err_addr   <= in_addr;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= in_store;
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_be    <= in_store ? st_be : 4'hF;
              mem_wdata <= in_store ? st_wd : '0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= !op_store && (resp_rd != 5'd0);
            resp_data  <= op_store ? '0 : ld_data;
            err_valid  <= 1'b0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == LAST) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= 1'b0;
            resp_data  <= '0;
            err_valid  <= 1'b1;
            err_cause  <= 2'd2;
            err_addr   <= op_addr;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_we    <= 1'b0;
          err_valid  <= 1'b0;
          in_ready   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed vectors with bus and response scoreboards.
// Bus responder acks after a per-op delay; monitors pop expectations.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_store = 1'b0;
  logic [4:0]  in_rd = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid, resp_we, err_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, err_addr;
  logic [1:0]  err_cause;

  lsu_mem_stage #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_store(in_store), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .err_valid(err_valid),
    .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          dly;
    int          len;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [1:0]  cause;
    logic [31:0] eaddr;
  } rsp_t;

  bus_t bq[$];
  rsp_t rq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bus_t mk_bus(input logic we, input logic [31:0] a,
      input logic [3:0] be, input logic [31:0] wd, input int dly,
      input int len, input logic [31:0] rdat);
    bus_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd;
    b.dly = dly; b.len = len; b.rdata = rdat;
    return b;
  endfunction

  function automatic rsp_t mk_rsp(input logic we, input logic [4:0] rd,
      input logic [31:0] d, input logic err, input logic [1:0] c,
      input logic [31:0] ea);
    rsp_t r;
    r.we = we; r.rd = rd; r.data = d; r.err = err; r.cause = c; r.eaddr = ea;
    return r;
  endfunction

  // Bus responder and request checker.
  bus_t cur;
  logic in_req = 1'b0;
  int   rcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_req  = 1'b0;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        rcnt = 0;
        check("req_expected", 32'(bq.size() > 0), 32'd1);
        if (bq.size() > 0) begin
          cur = bq.pop_front();
          check("mem_we", 32'(mem_we), 32'(cur.we));
          check("mem_addr", mem_addr, cur.addr);
          check("mem_be", 32'(mem_be), 32'(cur.be));
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        end else begin
          cur = mk_bus(1'b0, '0, '0, '0, -1, 0, '0);
        end
      end else begin
        rcnt++;
      end
      mem_ack   = (rcnt == cur.dly);
      mem_rdata = cur.rdata;
    end else begin
      if (in_req && cur.len > 0)
        check("req_len", 32'(rcnt + 1), 32'(cur.len));
      in_req  = 1'b0;
      mem_ack = 1'b0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      check("resp_expected", 32'(rq.size() > 0), 32'd1);
      if (rq.size() > 0) begin
        rsp_t e;
        e = rq.pop_front();
        check("resp_we", 32'(resp_we), 32'(e.we));
        check("resp_rd", 32'(resp_rd), 32'(e.rd));
        check("resp_data", resp_data, e.data);
        check("err_valid", 32'(err_valid), 32'(e.err));
        if (e.err) begin
          check("err_cause", 32'(err_cause), 32'(e.cause));
          check("err_addr", err_addr, e.eaddr);
        end
      end
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] wd,
      input logic [2:0] f3, input logic st, input logic [4:0] rd,
      input logic has_bus, input bus_t b, input logic has_rsp,
      input rsp_t r);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    if (has_bus) bq.push_back(b);
    if (has_rsp) rq.push_back(r);
    in_addr = a; in_wdata = wd; in_funct3 = f3;
    in_store = st; in_rd = rd; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input int lat);
    int k;
    k = 1;
    while (!resp_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("resp_seen", 32'(resp_valid), 32'd1);
    check("resp_latency", 32'(k), 32'(lat));
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] wd,
      input logic [2:0] f3, input logic st, input logic [4:0] rd,
      input logic has_bus, input bus_t b, input rsp_t r, input int lat);
    start_op(a, wd, f3, st, rd, has_bus, b, 1'b1, r);
    finish_op(lat);
  endtask

  bus_t nob;

  initial begin
    nob = mk_bus(1'b0, '0, '0, '0, -1, 0, '0);
    repeat (3) @(negedge clk);
    check("rst_ctrl", {26'd0, in_ready, mem_req, mem_we, resp_valid,
                       resp_we, err_valid}, 32'h20);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_small", {21'd0, mem_be, resp_rd, err_cause}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    rst = 1'b0;

    // LB sign extension, lane 3
    op(32'h1003, 0, 3'd0, 1'b0, 5'd5, 1'b1,
       mk_bus(1'b0, 32'h1000, 4'hF, 0, 0, 1, 32'h80AABBCC),
       mk_rsp(1'b1, 5'd5, 32'hFFFFFF80, 1'b0, 0, 0), 2);
    // SH upper half
    op(32'h2002, 32'h1234ABCD, 3'd1, 1'b1, 5'd7, 1'b1,
       mk_bus(1'b1, 32'h2000, 4'hC, 32'hABCDABCD, 0, 1, 0),
       mk_rsp(1'b0, 5'd7, 0, 1'b0, 0, 0), 2);
    // misaligned LW
    op(32'h3001, 0, 3'd2, 1'b0, 5'd1, 1'b0, nob,
       mk_rsp(1'b0, 5'd1, 0, 1'b1, 2'd0, 32'h3001), 1);
    // LBU lane 1, ack after 2 waits
    op(32'h1001, 0, 3'd4, 1'b0, 5'd9, 1'b1,
       mk_bus(1'b0, 32'h1000, 4'hF, 0, 2, 3, 32'h80AABBCC),
       mk_rsp(1'b1, 5'd9, 32'h000000BB, 1'b0, 0, 0), 4);
    // LH upper half, negative
    op(32'h1002, 0, 3'd1, 1'b0, 5'd10, 1'b1,
       mk_bus(1'b0, 32'h1000, 4'hF, 0, 1, 2, 32'h80AABBCC),
       mk_rsp(1'b1, 5'd10, 32'hFFFF80AA, 1'b0, 0, 0), 3);
    // LHU lower half
    op(32'h1000, 0, 3'd5, 1'b0, 5'd11, 1'b1,
       mk_bus(1'b0, 32'h1000, 4'hF, 0, 0, 1, 32'h80AABBCC),
       mk_rsp(1'b1, 5'd11, 32'h0000BBCC, 1'b0, 0, 0), 2);
    // LW to x0: data returned, no write
    op(32'h1004, 0, 3'd2, 1'b0, 5'd0, 1'b1,
       mk_bus(1'b0, 32'h1004, 4'hF, 0, 0, 1, 32'hDEADBEEF),
       mk_rsp(1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 0, 0), 2);
    // SB lane 1
    op(32'h2001, 32'h000000A5, 3'd0, 1'b1, 5'd0, 1'b1,
       mk_bus(1'b1, 32'h2000, 4'b0010, 32'hA5A5A5A5, 0, 1, 0),
       mk_rsp(1'b0, 5'd0, 0, 1'b0, 0, 0), 2);
    // SW
    op(32'h2004, 32'hCAFEF00D, 3'd2, 1'b1, 5'd2, 1'b1,
       mk_bus(1'b1, 32'h2004, 4'hF, 32'hCAFEF00D, 0, 1, 0),
       mk_rsp(1'b0, 5'd2, 0, 1'b0, 0, 0), 2);
    // misaligned SH
    op(32'h2001, 32'h1111, 3'd1, 1'b1, 5'd4, 1'b0, nob,
       mk_rsp(1'b0, 5'd4, 0, 1'b1, 2'd1, 32'h2001), 1);
    // illegal load funct3 3 beats misalignment
    op(32'h3001, 0, 3'd3, 1'b0, 5'd6, 1'b0, nob,
       mk_rsp(1'b0, 5'd6, 0, 1'b1, 2'd3, 32'h3001), 1);
    // illegal load funct3 6
    op(32'h3000, 0, 3'd6, 1'b0, 5'd6, 1'b0, nob,
       mk_rsp(1'b0, 5'd6, 0, 1'b1, 2'd3, 32'h3000), 1);
    // illegal store funct3 4
    op(32'h3000, 0, 3'd4, 1'b1, 5'd8, 1'b0, nob,
       mk_rsp(1'b0, 5'd8, 0, 1'b1, 2'd3, 32'h3000), 1);

`ifdef LSU_TIMEOUT_EN
    // no ack: request held 4 cycles then cause 2
    op(32'h5000, 0, 3'd2, 1'b0, 5'd12, 1'b1,
       mk_bus(1'b0, 32'h5000, 4'hF, 0, -1, 4, 0),
       mk_rsp(1'b0, 5'd12, 0, 1'b1, 2'd2, 32'h5000), 5);
    @(negedge clk);
    check("ready_after_timeout", 32'(in_ready), 32'd1);
    // ack in the last allowed cycle wins over timeout
    op(32'h5004, 0, 3'd2, 1'b0, 5'd13, 1'b1,
       mk_bus(1'b0, 32'h5004, 4'hF, 0, 3, 4, 32'h01020304),
       mk_rsp(1'b1, 5'd13, 32'h01020304, 1'b0, 0, 0), 5);
`endif

    // reset during REQ aborts without a response
    start_op(32'h6000, 0, 3'd2, 1'b0, 5'd3, 1'b1,
             mk_bus(1'b0, 32'h6000, 4'hF, 0, -1, 0, 0), 1'b0,
             mk_rsp(1'b0, 0, 0, 1'b0, 0, 0));
    @(negedge clk);
    check("req_before_rst", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("req_after_rst", 32'(mem_req), 32'd0);
    check("resp_after_rst", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // LHU after reset recovery
    op(32'h4000, 0, 3'd5, 1'b0, 5'd14, 1'b1,
       mk_bus(1'b0, 32'h4000, 4'hF, 0, 0, 1, 32'h0000F00D),
       mk_rsp(1'b1, 5'd14, 32'h0000F00D, 1'b0, 0, 0), 2);

    repeat (4) @(negedge clk);
    check("bus_queue_empty", 32'(bq.size()), 32'd0);
    check("resp_queue_empty", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
